// File: rtl/grid_mover_if.sv
// Player-side bundle for grid_mover: controls, bomb/opponent view in; position and step pulses out.
interface grid_mover_if #(
   parameter int COORD_W   = 10,
   parameter int NUM_BOMBS = 6,
   parameter int BOMB_W    = 6
);
   logic                        enable;
   logic                        btn_up;
   logic                        btn_down;
   logic                        btn_left;
   logic                        btn_right;
   logic [NUM_BOMBS*BOMB_W-1:0] bomb_x;
   logic [NUM_BOMBS*BOMB_W-1:0] bomb_y;
   logic [NUM_BOMBS-1:0]        bomb_valid;
   logic [COORD_W-1:0]          other_x;
   logic [COORD_W-1:0]          other_y;
   logic [COORD_W-1:0]          pos_x;
   logic [COORD_W-1:0]          pos_y;
   logic [1:0]                  facing;
   logic                        moved;
   logic                        blocked;

   modport master (
      output enable, btn_up, btn_down, btn_left, btn_right,
      output bomb_x, bomb_y, bomb_valid, other_x, other_y,
      input  pos_x, pos_y, facing, moved, blocked
   );

   modport slave (
      input  enable, btn_up, btn_down, btn_left, btn_right,
      input  bomb_x, bomb_y, bomb_valid, other_x, other_y,
      output pos_x, pos_y, facing, moved, blocked
   );
endinterface

// File: rtl/grid_mover.sv
// Per-player movement controller: tick-divided single-cell steps with press-then-auto-repeat.
// Define WRAP_EN to make horizontal moves wrap across the left/right edges (vertical always clamps).
module grid_mover #(
   parameter int GRID_W       = 40,
   parameter int GRID_H       = 30,
   parameter int COORD_W      = 10,
   parameter int NUM_BOMBS    = 6,
   parameter int BOMB_W       = 6,
   parameter int TICK_DIV     = 50000,
   parameter int REPEAT_TICKS = 150,
   parameter int START_X      = 39,
   parameter int START_Y      = 29
) (
   input  logic        clk,
   input  logic        rst,
   grid_mover_if.slave bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_HOLD} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   state_t             state_q, state_d;
   dir_t               dir_q, dir_d, sel_dir;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [RW-1:0]      rep_q, rep_d;
   logic [1:0]         facing_q, facing_d;
   logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
   logic [COORD_W-1:0] cand_x, cand_y;
   logic               legal_q, legal_d;
   logic               moved_q, moved_d, blocked_q, blocked_d;
   logic               tick, dir_any, in_bounds, lane_ok, bomb_hit, other_hit;

   assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   assign dir_any    = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;

   always_comb begin
      sel_dir = D_UP;
      if (bus.btn_up)         sel_dir = D_UP;
      else if (bus.btn_down)  sel_dir = D_DOWN;
      else if (bus.btn_left)  sel_dir = D_LEFT;
      else if (bus.btn_right) sel_dir = D_RIGHT;
   end

   // Candidate cell for the latched direction; lane rule keys off the coordinate that stays fixed.
   always_comb begin
      cand_x    = pos_x_q;
      cand_y    = pos_y_q;
      in_bounds = 1'b0;
      lane_ok   = 1'b0;
      case (dir_q)
         D_UP: begin
            in_bounds = (pos_y_q != '0);
            lane_ok   = pos_x_q[0];
            cand_y    = pos_y_q - COORD_W'(1);
         end
         D_DOWN: begin
            in_bounds = (pos_y_q < COORD_W'(GRID_H - 1));
            lane_ok   = pos_x_q[0];
            cand_y    = pos_y_q + COORD_W'(1);
         end
         D_LEFT: begin
            lane_ok = pos_y_q[0];
            if (pos_x_q != '0) begin
               in_bounds = 1'b1;
               cand_x    = pos_x_q - COORD_W'(1);
            end else begin
`ifdef WRAP_EN
               in_bounds = 1'b1;
               cand_x    = COORD_W'(GRID_W - 1);
`else
               in_bounds = 1'b0;
`endif
            end
         end
         default: begin
            lane_ok = pos_y_q[0];
            if (pos_x_q < COORD_W'(GRID_W - 1)) begin
               in_bounds = 1'b1;
               cand_x    = pos_x_q + COORD_W'(1);
            end else begin
`ifdef WRAP_EN
               in_bounds = 1'b1;
               cand_x    = '0;
`else
               in_bounds = 1'b0;
`endif
            end
         end
      endcase
   end

   always_comb begin
      bomb_hit = 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
         if (bus.bomb_valid[i] &&
             (COORD_W'(bus.bomb_x[i*BOMB_W +: BOMB_W]) == cand_x) &&
             (COORD_W'(bus.bomb_y[i*BOMB_W +: BOMB_W]) == cand_y))
            bomb_hit = 1'b1;
      end
   end

   assign other_hit = (cand_x == bus.other_x) && (cand_y == bus.other_y);

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      facing_d  = facing_q;
      rep_d     = rep_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      legal_d   = legal_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
      if (bus.enable) begin
         case (state_q)
            S_IDLE: begin
               if (tick && dir_any) begin
                  dir_d    = sel_dir;
                  facing_d = sel_dir;
                  state_d  = S_CHECK;
               end
            end
            S_CHECK: begin
               tx_d    = cand_x;
               ty_d    = cand_y;
               legal_d = in_bounds && lane_ok && !bomb_hit && !other_hit;
               state_d = S_COMMIT;
            end
            S_COMMIT: begin
               if (legal_q) begin
                  pos_x_d = tx_q;
                  pos_y_d = ty_q;
                  moved_d = 1'b1;
               end else begin
                  blocked_d = 1'b1;
               end
               rep_d   = RW'(REPEAT_TICKS);
               state_d = S_HOLD;
            end
            default: begin
               if (!dir_any) begin
                  state_d = S_IDLE;
               end else if (tick) begin
                  if (rep_q != '0) rep_d = rep_q - RW'(1);
                  if (sel_dir != dir_q) begin
                     dir_d    = sel_dir;
                     facing_d = sel_dir;
                     state_d  = S_CHECK;
                  end else if (rep_q <= RW'(1)) begin
                     state_d = S_CHECK;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         rep_q      <= '0;
         facing_q   <= 2'd1;
         pos_x_q    <= COORD_W'(START_X);
         pos_y_q    <= COORD_W'(START_Y);
         moved_q    <= 1'b0;
         blocked_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         rep_q      <= rep_d;
         facing_q   <= facing_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         moved_q    <= moved_d;
         blocked_q  <= blocked_d;
      end
   end

   // Latched direction and pending target are only consumed after IDLE has loaded them.
   always_ff @(posedge clk) begin
      dir_q   <= dir_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      legal_q <= legal_d;
   end

   assign bus.pos_x   = pos_x_q;
   assign bus.pos_y   = pos_y_q;
   assign bus.facing  = facing_q;
   assign bus.moved   = moved_q;
   assign bus.blocked = blocked_q;
endmodule

// File: tb/tb_grid_mover.sv
// Self-checking bench for grid_mover: directed scenarios plus random moves against a rule-level model.
module tb_grid_mover;
   localparam int GW = 40;
   localparam int GH = 30;
   localparam int CW = 10;
   localparam int NB = 6;
   localparam int BW = 6;
   localparam int TD = 4;
   localparam int RT = 3;
   localparam int SX = 39;
   localparam int SY = 29;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   grid_mover_if #(.COORD_W(CW), .NUM_BOMBS(NB), .BOMB_W(BW)) bus ();

   grid_mover #(
      .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .NUM_BOMBS(NB), .BOMB_W(BW),
      .TICK_DIV(TD), .REPEAT_TICKS(RT), .START_X(SX), .START_Y(SY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int nedge    = 0;
   int px, py;
   int bx [NB];
   int by [NB];
   bit bv [NB];
   int ox, oy;

   // Edges since reset release; the tick is high in each cycle where nedge % TD == TD-1.
   always @(posedge clk) begin
      if (rst) nedge <= 0;
      else     nedge <= nedge + 1;
   end

   initial begin
      #2000000;
      $fatal(1, "FAIL global_timeout: observed no finish, expected finish");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input logic [3:0] b);
      bus.btn_up    = b[0];
      bus.btn_down  = b[1];
      bus.btn_left  = b[2];
      bus.btn_right = b[3];
   endtask

   task automatic drive_env();
      for (int i = 0; i < NB; i++) begin
         bus.bomb_x[i*BW +: BW] = BW'(bx[i]);
         bus.bomb_y[i*BW +: BW] = BW'(by[i]);
         bus.bomb_valid[i]      = bv[i];
      end
      bus.other_x = CW'(ox);
      bus.other_y = CW'(oy);
   endtask

   function automatic int dir_of(input logic [3:0] b);
      if (b[0]) return 0;
      if (b[1]) return 1;
      if (b[2]) return 2;
      return 3;
   endfunction

   // Rule-level step model: returns legality and the target cell for a move from (x,y).
   function automatic bit model(input int x, input int y, input int d, output int nx, output int ny);
      bit ok;
      nx = x;
      ny = y;
      ok = 1'b1;
      case (d)
         0: begin ok = (y > 0) && (x % 2 == 1); ny = y - 1; end
         1: begin ok = (y < GH - 1) && (x % 2 == 1); ny = y + 1; end
         2: begin
            ok = (y % 2 == 1);
            if (x > 0) nx = x - 1;
            else begin
`ifdef WRAP_EN
               nx = GW - 1;
`else
               ok = 1'b0;
`endif
            end
         end
         default: begin
            ok = (y % 2 == 1);
            if (x < GW - 1) nx = x + 1;
            else begin
`ifdef WRAP_EN
               nx = 0;
`else
               ok = 1'b0;
`endif
            end
         end
      endcase
      for (int i = 0; i < NB; i++)
         if (bv[i] && bx[i] == nx && by[i] == ny) ok = 1'b0;
      if (ox == nx && oy == ny) ok = 1'b0;
      return ok;
   endfunction

   task automatic quiet(input int n, input string tag);
      int cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.moved || bus.blocked) cnt++;
      end
      chk(tag, cnt, 0);
   endtask

   // Press b and check n consecutive step attempts (first on the next tick, then every RT ticks).
   task automatic run(input logic [3:0] b, input int n, input bit keep);
      int d, nx, ny, t_exp;
      bit ok, got;
      d = dir_of(b);
      set_btn(b);
      t_exp = ((nedge + TD) / TD) * TD + 2;
      for (int k = 0; k < n; k++) begin
         ok  = model(px, py, d, nx, ny);
         got = 1'b0;
         for (int w = 0; w < TD * (RT + 2) + 8 && !got; w++) begin
            @(negedge clk);
            got = bus.moved || bus.blocked;
         end
         chk("pulse_seen", got, 1);
         chk("latency", nedge, t_exp);
         chk("moved", bus.moved, ok);
         chk("blocked", bus.blocked, !ok);
         chk("facing", bus.facing, d);
         if (ok) begin
            px = nx;
            py = ny;
         end
         chk("pos_x", bus.pos_x, px);
         chk("pos_y", bus.pos_y, py);
         t_exp = t_exp + TD * RT;
      end
      if (!keep) begin
         set_btn(4'b0000);
         quiet(2, "no_extra_after_release");
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.enable = 1'b1;
      set_btn(4'b0000);
      for (int i = 0; i < NB; i++) begin bx[i] = 0; by[i] = 0; bv[i] = 1'b0; end
      ox = 1000; oy = 1000;
      drive_env();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_pos_x", bus.pos_x, 39);
      chk("rst_pos_y", bus.pos_y, 29);
      chk("rst_facing", bus.facing, 1);
      chk("rst_moved", bus.moved, 0);
      chk("rst_blocked", bus.blocked, 0);
      px = SX; py = SY;

      // Hold up: first step on the first tick, second after RT more ticks, then silence on release.
      run(4'b0001, 2, 1'b0);
      chk("hold_up_y", bus.pos_y, 27);
      quiet(20, "idle_after_release");
      run(4'b0010, 2, 1'b0);

      // Lane rule: x even blocks vertical; then move on along the odd row.
      run(4'b0100, 1, 1'b0);
      run(4'b0001, 1, 1'b0);
      chk("lane_block_x", bus.pos_x, 38);
      run(4'b0100, 1, 1'b0);
      chk("lane_left_x", bus.pos_x, 37);

      // Bomb slot 2 in the way, then cleared.
      bx[2] = 37; by[2] = 28; bv[2] = 1'b1; drive_env();
      run(4'b0001, 1, 1'b0);
      chk("bomb_block_y", bus.pos_y, 29);
      bv[2] = 1'b0; drive_env();
      run(4'b0001, 1, 1'b0);
      chk("bomb_clear_y", bus.pos_y, 28);
      run(4'b0010, 1, 1'b0);
      run(4'b1000, 2, 1'b0);

      // Other player occupies the target cell.
      ox = 38; oy = 29; drive_env();
      run(4'b0100, 1, 1'b0);
      chk("other_block_x", bus.pos_x, 39);
      ox = 1000; oy = 1000; drive_env();

      // Direction change while holding retargets on the next tick.
      run(4'b0001, 1, 1'b1);
      run(4'b0010, 1, 1'b0);

      // enable=0 freezes movement out of IDLE.
      bus.enable = 1'b0;
      set_btn(4'b0001);
      quiet(3 * TD, "disabled_no_pulse");
      chk("disabled_pos_y", bus.pos_y, py);
      bus.enable = 1'b1;
      run(4'b0001, 1, 1'b0);
      run(4'b0010, 1, 1'b0);

      // up+right: up wins; then reset in the middle of HOLD.
      run(4'b1001, 1, 1'b1);
      chk("prio_up_y", bus.pos_y, 28);
      chk("prio_up_x", bus.pos_x, 39);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_btn(4'b0000);
      px = SX; py = SY;
      chk("midrst_pos_x", bus.pos_x, 39);
      chk("midrst_pos_y", bus.pos_y, 29);
      chk("midrst_facing", bus.facing, 1);
      quiet(2 * TD, "midrst_idle");

      // Walk to (0,1) and probe the left edge, then the right move from there.
      run(4'b0001, 28, 1'b0);
      run(4'b0100, 39, 1'b0);
      chk("edge_x", bus.pos_x, 0);
      run(4'b0100, 1, 1'b0);
      run(4'b1000, 1, 1'b0);

      // Random moves with bombs and opponent clustered around the player.
      for (int it = 0; it < 30; it++) begin
         logic [3:0] b;
         int r;
         b = 4'($urandom_range(1, 15));
         for (int i = 0; i < NB; i++) begin
            bv[i] = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 2));
            bx[i] = (px + r - 1 < 0) ? 0 : px + r - 1;
            r = int'($urandom_range(0, 2));
            by[i] = (py + r - 1 < 0) ? 0 : py + r - 1;
         end
         if ($urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(0, 2));
            ox = (px + r - 1 < 0) ? 0 : px + r - 1;
            r = int'($urandom_range(0, 2));
            oy = (py + r - 1 < 0) ? 0 : py + r - 1;
         end else begin
            ox = 1000; oy = 1000;
         end
         drive_env();
         repeat ($urandom_range(0, 7)) @(negedge clk);
         run(b, int'($urandom_range(1, 2)), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/grid_mover.md
Name: grid_mover

Overview:
- Parametrised per-player movement controller for the bomb-man playfield.
- Converts debounced direction buttons into single-cell grid steps at a divided tick rate, with press-then-auto-repeat timing.
- Enforces lane rules, edge bounds, bomb-slot collisions and collision with the other player.
- One instance per player; pos_x/pos_y feed the renderer and the opponent instance's other_x/other_y.

Parameters:
- GRID_W, 40, playfield width in cells; valid x is 0..GRID_W-1.
- GRID_H, 30, playfield height in cells; valid y is 0..GRID_H-1.
- COORD_W, 10, width of position and other-player coordinates.
- NUM_BOMBS, 6, number of bomb slots checked for collision.
- BOMB_W, 6, width of each bomb-slot coordinate; zero-extended to COORD_W before compare.
- TICK_DIV, 50000, clk cycles per movement tick (1 ms at 50 MHz).
- REPEAT_TICKS, 150, ticks between auto-repeat steps while a direction is held.
- START_X, 39, x loaded on reset.
- START_Y, 29, y loaded on reset.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, 0 freezes movement; ticks keep counting.
- btn_up, input, 1, debounced level, up (y-1).
- btn_down, input, 1, debounced level, down (y+1).
- btn_left, input, 1, debounced level, left (x-1).
- btn_right, input, 1, debounced level, right (x+1).
- bomb_x, input, NUM_BOMBS*BOMB_W, flattened slot x; slot i is bits [i*BOMB_W +: BOMB_W].
- bomb_y, input, NUM_BOMBS*BOMB_W, flattened slot y, same packing.
- bomb_valid, input, NUM_BOMBS, per-slot occupied flag; invalid slots are ignored.
- other_x, input, COORD_W, other player x.
- other_y, input, COORD_W, other player y.
- pos_x, output, COORD_W, current x.
- pos_y, output, COORD_W, current y.
- facing, output, 2, last requested direction: 0 up, 1 down, 2 left, 3 right.
- moved, output, 1, one-cycle pulse on each committed step.
- blocked, output, 1, one-cycle pulse when an attempted step is rejected.

Behaviour:
- Reset: pos_x=START_X, pos_y=START_Y, facing=1, moved=0, blocked=0, tick counter=0, repeat counter=0, state IDLE. A reset mid-operation discards any pending target.
- Tick: a counter of 0..TICK_DIV-1 drives tick high for one clk when the counter wraps.
- Direction select: priority up > down > left > right. Multiple buttons resolve to the highest-priority one; dir_any = OR of all four buttons.
- IDLE: on tick && dir_any && enable, latch dir, set facing=dir, go to CHECK.
- CHECK (1 cycle): compute the registered target (tx,ty). The step is legal only if all of these hold:
  - In bounds: up needs y>0, down needs y<GRID_H-1, left needs x>0, right needs x<GRID_W-1.
  - Lane rule: vertical steps need x odd; horizontal steps need y odd.
  - No valid bomb slot equals (tx,ty).
  - (tx,ty) differs from (other_x,other_y).
  - Go to COMMIT.
- COMMIT (1 cycle):
  - If legal, update pos to (tx,ty) and pulse moved=1; otherwise pulse blocked=1.
  - Load repeat counter=REPEAT_TICKS and go to HOLD.
- HOLD:
  - On each tick the repeat counter decrements.
  - If all buttons are released, go to IDLE.
  - If the highest-priority pressed button differs from the latched dir on a tick, latch the new dir, set facing, and go to CHECK immediately.
  - If the counter reaches 0 on a tick with the same dir held, go to CHECK.
- Latency: from a tick with a button held, pos updates 2 clk later (CHECK, COMMIT). At most one step per tick.
- enable=0: no transitions out of IDLE or HOLD; pos, facing and counters hold; moved and blocked stay 0.
- Inputs (bombs, other player) are sampled only in CHECK; changes during COMMIT do not revoke the decision.
- moved and blocked are never high in the same cycle.

Optional Feature:
- WRAP_EN defined:
  - Horizontal edges wrap: left from x=0 goes to GRID_W-1, right from GRID_W-1 goes to 0. Lane, bomb and player checks apply to the wrapped target.
  - Vertical movement still clamps at the edges.
- WRAP_EN undefined: all edges clamp, and an attempt to step past an edge pulses blocked.

Test Plan:
- Reset with defaults, TICK_DIV=4 -> pos=(39,29), facing=1, moved=0, blocked=0.
- From (39,29), hold btn_up, REPEAT_TICKS=3 -> moved at 2 clk after the first tick, pos_y=28; next step after 3 further ticks, pos_y=27; release -> IDLE with no further moves.
- Start (38,29), press btn_up -> x even, so blocked pulses and pos is unchanged; press btn_left -> pos=(37,29).
- Bomb slot 2 valid at (37,28), pos=(37,29), btn_up -> blocked; clear bomb_valid[2] and re-press -> pos=(37,28).
- other=(38,29), pos=(39,29), btn_left -> blocked; with WRAP_EN at pos=(0,1), btn_left -> pos=(39,1); without WRAP_EN -> blocked, pos stays (0,1).
- btn_up and btn_right together at (39,29) -> up wins, pos_y=28; assert rst mid-HOLD -> pos=(39,29), state IDLE next cycle.
